// File: rtl/ysyx_lsu.sv
// Load/store unit: formats one RV32I load/store onto a req/gnt/rvalid bus and returns the result to writeback.
// Latency: 3 cycles minimum (accept, grant, response, result); a misaligned trap completes in 1 cycle.
// Backpressure: single outstanding access; in_ready only in IDLE, mem_req held until mem_gnt, result held until out_ready.
// Optional: define YSYX_LSU_MISALIGN_TRAP_EN to add out_misalign and trap misaligned halfword/word accesses.
module ysyx_lsu #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  // execute-stage side
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_store,
  input  logic [RD_W-1:0] in_rd,
  // memory bus side
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  // writeback side
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
  ,
  output logic            out_misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // captured access, held stable for the whole transaction
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      funct3_q;
  logic            is_store_q;
  logic [RD_W-1:0] rd_q;
  logic [XLEN-1:0] rdata_q;
  logic            misalign_q;

  logic            accept;
  logic            misalign;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;

  assign accept = (state_q == IDLE) && in_valid;

  // funct3[1:0]: 00 byte, 01 halfword, anything else is a word access
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
  assign misalign = (in_funct3[1:0] == 2'b01) ? in_addr[0]
                  : ((in_funct3[1:0] != 2'b00) && (in_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // state register; async reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    mem_req   = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // capture the request on accept, latch the formatted result on response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      rd_q       <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= in_addr;
        wdata_q    <= in_wdata;
        funct3_q   <= in_funct3;
        is_store_q <= in_is_store;
        rd_q       <= in_rd;
        misalign_q <= misalign;
        rdata_q    <= '0;
      end
      if ((state_q == RESP) && mem_rvalid) begin
        rdata_q <= is_store_q ? '0 : ld_data;
      end
    end
  end

  // store lane replication and byte enables from the captured offset
  always_comb begin
    st_wdata = wdata_q;
    st_wstrb = 4'b1111;
    case (funct3_q[1:0])
      2'b00: begin
        st_wdata = {4{wdata_q[7:0]}};
        st_wstrb = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_wdata = {2{wdata_q[15:0]}};
        st_wstrb = 4'b0011 << {addr_q[1], 1'b0};
      end
      default: ;
    endcase
  end

  // load lane select and sign/zero extension
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign mem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata = st_wdata;
  assign mem_we    = mem_req && is_store_q;
  assign mem_wstrb = (mem_req && is_store_q) ? st_wstrb : 4'b0000;

  assign out_rdata = rdata_q;
  assign out_rd    = rd_q;
  assign out_wen   = !is_store_q && (rd_q != '0) && !misalign_q;

`ifdef YSYX_LSU_MISALIGN_TRAP_EN
  assign out_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_ysyx_lsu.sv
module tb_ysyx_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_funct3;
  logic        in_is_store;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_wen;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
  logic        out_misalign;
`endif

  always #5 clk = ~clk;

  ysyx_lsu #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_funct3(in_funct3), .in_is_store(in_is_store), .in_rd(in_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_wen(out_wen)
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    , .out_misalign(out_misalign)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        st;
    logic [4:0]  rd;
    logic [31:0] rdata;     // word the bus returns
    logic [31:0] e_maddr;
    logic [31:0] e_mwdata;  // only meaningful for stores
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
    logic        e_wen;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        wen;
  } res_t;

  vec_t vecs[$];
  res_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                              input logic st, input logic [4:0] rd, input logic [31:0] rdata,
                              input logic [31:0] e_maddr, input logic [31:0] e_mwdata,
                              input logic [3:0] e_wstrb, input logic [31:0] e_rdata, input logic e_wen);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.f3 = f3; v.st = st; v.rd = rd; v.rdata = rdata;
    v.e_maddr = e_maddr; v.e_mwdata = e_mwdata; v.e_wstrb = e_wstrb;
    v.e_rdata = e_rdata; v.e_wen = e_wen;
    return v;
  endfunction

  // One full transaction with gd grant-stall cycles, rdl response-stall cycles and od writeback-stall cycles.
  task automatic run_txn(input vec_t v, input int gd, input int rdl, input int od);
    res_t r;
    res_t e;
    int   lat;
    @(negedge clk);
    chk1("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; in_addr = v.addr; in_wdata = v.wdata;
    in_funct3 = v.f3; in_is_store = v.st; in_rd = v.rd;
    r.rdata = v.e_rdata; r.rd = v.rd; r.wen = v.e_wen;
    sb_q.push_back(r);
    lat = 0;
    @(negedge clk); lat++;
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
    in_funct3 = 3'($urandom); in_rd = 5'($urandom);
    for (int i = 0; i <= gd; i++) begin
      chk1("mem_req", mem_req, 1'b1);
      chk1("in_ready_busy", in_ready, 1'b0);
      chk32("mem_addr", mem_addr, v.e_maddr);
      chk1("mem_we", mem_we, v.st);
      chk32("mem_wstrb", 32'(mem_wstrb), 32'(v.e_wstrb));
      if (v.st) chk32("mem_wdata", mem_wdata, v.e_mwdata);
      if (i == gd) mem_gnt = 1'b1;
      @(negedge clk); lat++;
    end
    mem_gnt = 1'b0;
    for (int i = 0; i < rdl; i++) begin
      chk1("mem_req_after_gnt", mem_req, 1'b0);
      chk1("out_valid_early", out_valid, 1'b0);
      @(negedge clk); lat++;
    end
    mem_rvalid = 1'b1; mem_rdata = v.rdata;
    @(negedge clk); lat++;
    mem_rvalid = 1'b0; mem_rdata = $urandom;
    chk32("latency", 32'(lat), 32'(3 + gd + rdl));
    chk1("out_valid", out_valid, 1'b1);
    for (int i = 0; i < od; i++) begin
      chk1("hold_out_valid", out_valid, 1'b1);
      chk32("hold_out_rdata", out_rdata, v.e_rdata);
      chk1("hold_in_ready", in_ready, 1'b0);
      out_ready = 1'b0;
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = ~v.rdata;
      @(negedge clk);
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      e = sb_q.pop_front();
      chk1("out_valid_pop", out_valid, 1'b1);
      chk32("out_rdata", out_rdata, e.rdata);
      chk32("out_rd", 32'(out_rd), 32'(e.rd));
      chk1("out_wen", out_wen, e.wen);
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
      chk1("out_misalign_normal", out_misalign, 1'b0);
`endif
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("in_ready_after_done", in_ready, 1'b1);
    chk1("out_valid_after_done", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
    in_is_store = 1'b0; in_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    out_ready = 1'b0;

    //        addr          wdata         f3     st    rd     rdata         e_maddr       e_mwdata      wstrb    e_rdata       wen
    vecs.push_back(mk(32'h8000_0003, 32'h0, 3'b000, 1'b0, 5'd5, 32'h80FF_1234, 32'h8000_0000, 32'h0, 4'b0000, 32'hFFFF_FF80, 1'b1));
    vecs.push_back(mk(32'h8000_0002, 32'h0, 3'b101, 1'b0, 5'd0, 32'hBEEF_0000, 32'h8000_0000, 32'h0, 4'b0000, 32'h0000_BEEF, 1'b0));
    vecs.push_back(mk(32'h0000_0010, 32'h0000_00AB, 3'b000, 1'b1, 5'd7, 32'h0, 32'h0000_0010, 32'hABAB_ABAB, 4'b0001, 32'h0, 1'b0));
    vecs.push_back(mk(32'h0000_0101, 32'h0, 3'b100, 1'b0, 5'd1, 32'h1234_5678, 32'h0000_0100, 32'h0, 4'b0000, 32'h0000_0056, 1'b1));
    vecs.push_back(mk(32'h0000_0200, 32'h0, 3'b001, 1'b0, 5'd31, 32'h1234_F00D, 32'h0000_0200, 32'h0, 4'b0000, 32'hFFFF_F00D, 1'b1));
    vecs.push_back(mk(32'h0000_0022, 32'h1234_ABCD, 3'b001, 1'b1, 5'd9, 32'h0, 32'h0000_0020, 32'hABCD_ABCD, 4'b1100, 32'h0, 1'b0));
    vecs.push_back(mk(32'h0000_0040, 32'hCAFE_F00D, 3'b010, 1'b1, 5'd3, 32'h0, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0));
    vecs.push_back(mk(32'h0000_0012, 32'hFFFF_FF5A, 3'b000, 1'b1, 5'd0, 32'h0, 32'h0000_0010, 32'h5A5A_5A5A, 4'b0100, 32'h0, 1'b0));
    vecs.push_back(mk(32'h0000_0008, 32'h0, 3'b011, 1'b0, 5'd12, 32'h0102_0304, 32'h0000_0008, 32'h0, 4'b0000, 32'h0102_0304, 1'b1));
    vecs.push_back(mk(32'h0000_0030, 32'h1122_3344, 3'b111, 1'b1, 5'd4, 32'h0, 32'h0000_0030, 32'h1122_3344, 4'b1111, 32'h0, 1'b0));
    vecs.push_back(mk(32'h0000_0000, 32'h0, 3'b101, 1'b0, 5'd3, 32'hFFFF_8000, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_8000, 1'b1));
    vecs.push_back(mk(32'h0000_0000, 32'h0, 3'b000, 1'b0, 5'd6, 32'h0000_007F, 32'h0000_0000, 32'h0, 4'b0000, 32'h0000_007F, 1'b1));
`ifndef YSYX_LSU_MISALIGN_TRAP_EN
    // misaligned addresses: low bits silently ignored
    vecs.push_back(mk(32'h0000_0006, 32'h0, 3'b010, 1'b0, 5'd2, 32'hDEAD_BEEF, 32'h0000_0004, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b1));
    vecs.push_back(mk(32'h0000_0003, 32'h0, 3'b001, 1'b0, 5'd8, 32'h8001_7FFF, 32'h0000_0000, 32'h0, 4'b0000, 32'hFFFF_8001, 1'b1));
    vecs.push_back(mk(32'h0000_0005, 32'h0000_BEEF, 3'b001, 1'b1, 5'd8, 32'h0, 32'h0000_0004, 32'hBEEF_BEEF, 4'b0011, 32'h0, 1'b0));
`endif

    // reset state
    #1;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_wstrb", 32'(mem_wstrb), 32'h0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_wen", out_wen, 1'b0);
    chk32("rst_out_rdata", out_rdata, 32'h0);
    chk32("rst_out_rd", 32'(out_rd), 32'h0);
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    chk1("rst_out_misalign", out_misalign, 1'b0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // stray bus responses in IDLE are ignored
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk1("idle_stray_in_ready", in_ready, 1'b1);
    chk1("idle_stray_out_valid", out_valid, 1'b0);
    chk1("idle_stray_mem_req", mem_req, 1'b0);

    // zero-wait table
    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], 0, 0, 0);

    // stalls on every side
    run_txn(vecs[0], 3, 2, 2);
    run_txn(vecs[2], 3, 2, 2);
    run_txn(vecs[5], 1, 4, 1);

    // reset while waiting for grant
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h100; in_funct3 = 3'b010; in_is_store = 1'b1; in_rd = 5'd1;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("req_before_rst", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rst_req_mem_req", mem_req, 1'b0);
    chk1("rst_req_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // reset while waiting for response, then a stray late response
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h200; in_funct3 = 3'b010; in_is_store = 1'b0; in_rd = 5'd2;
    @(negedge clk);
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk1("resp_in_ready", in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("rst_resp_mem_req", mem_req, 1'b0);
    chk1("rst_resp_in_ready", in_ready, 1'b1);
    chk1("rst_resp_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk1("late_rvalid_out_valid", out_valid, 1'b0);
    chk1("late_rvalid_in_ready", in_ready, 1'b1);
    @(negedge clk);
    chk1("late_rvalid_out_valid2", out_valid, 1'b0);

    // normal operation resumes after the abort
    run_txn(vecs[3], 0, 1, 0);

`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    // misaligned word load traps straight to DONE
    @(negedge clk);
    in_valid = 1'b1; in_addr = 32'h6; in_funct3 = 3'b010; in_is_store = 1'b0; in_rd = 5'd4;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("mis_mem_req", mem_req, 1'b0);
    chk1("mis_out_valid", out_valid, 1'b1);
    chk1("mis_out_misalign", out_misalign, 1'b1);
    chk1("mis_out_wen", out_wen, 1'b0);
    chk32("mis_out_rdata", out_rdata, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk1("mis_in_ready", in_ready, 1'b1);
    // misaligned halfword store
    in_valid = 1'b1; in_addr = 32'h3; in_funct3 = 3'b001; in_is_store = 1'b1; in_rd = 5'd0;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("mis_h_mem_req", mem_req, 1'b0);
    chk1("mis_h_out_misalign", out_misalign, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    run_txn(vecs[1], 0, 0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
